// File: rtl/sdp_x_alu_cfg_triosy_sync_rx.sv
// Collects per-field triosy done strobes from the X-ALU core and raises one
// layer-done request per layer, buffering strobes that run ahead into the next layer.
module sdp_x_alu_cfg_triosy_sync_rx #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rst,
    input  logic [NUM_CH-1:0] triosy_lz,
    input  logic [NUM_CH-1:0] ch_en,
    output logic              done_vld,
    input  logic              done_rdy,
    output logic [NUM_CH-1:0] pend_mask,
    output logic [CNT_W-1:0]  layer_cnt,
    output logic              err_dup,
    input  logic              err_clr
);

    typedef enum logic [1:0] {IDLE, COLLECT, REPORT} state_t;

    state_t            state, state_nxt;
    logic [NUM_CH-1:0] nxt_mask, pend_n, nxt_n;
    logic [NUM_CH-1:0] lz_v, acc, hand_mask;
    logic              vld_n, dup, hs;

    always_comb begin
        lz_v      = triosy_lz & ch_en;
        hs        = done_vld & done_rdy;
        acc       = pend_mask | lz_v;
        hand_mask = nxt_mask | lz_v;
        state_nxt = state;
        pend_n    = pend_mask;
        nxt_n     = nxt_mask;
        vld_n     = done_vld;
        dup       = 1'b0;
        case (state)
            IDLE: begin
                if (ch_en != '0 && lz_v != '0) begin
                    pend_n = lz_v;
                    if (lz_v == ch_en) begin
                        state_nxt = REPORT;
                        vld_n     = 1'b1;
                    end else begin
                        state_nxt = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (ch_en == '0) begin
                    state_nxt = IDLE;
                    pend_n    = '0;
                end else begin
                    pend_n = acc;
                    dup    = |(lz_v & pend_mask);
                    // stale bits of since-disabled channels are masked out here
                    if ((acc & ch_en) == ch_en) begin
                        state_nxt = REPORT;
                        vld_n     = 1'b1;
                    end
                end
            end
            REPORT: begin
                dup = |(lz_v & nxt_mask);
                if (hs) begin
                    // the early strobes seed the next layer; a fully covered
                    // next layer re-raises done_vld after one idle cycle
                    vld_n  = 1'b0;
                    pend_n = hand_mask;
                    nxt_n  = '0;
                    if (hand_mask == '0)
                        state_nxt = IDLE;
                    else if (ch_en != '0 && (hand_mask & ch_en) == ch_en)
                        state_nxt = REPORT;
                    else
                        state_nxt = COLLECT;
                end else begin
                    vld_n = 1'b1;
                    nxt_n = hand_mask;
                end
            end
            default: begin
                state_nxt = IDLE;
                pend_n    = '0;
                nxt_n     = '0;
                vld_n     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state     <= IDLE;
            pend_mask <= '0;
            nxt_mask  <= '0;
            done_vld  <= 1'b0;
            layer_cnt <= '0;
            err_dup   <= 1'b0;
        end else begin
            state     <= state_nxt;
            pend_mask <= pend_n;
            nxt_mask  <= nxt_n;
            done_vld  <= vld_n;
            if (hs)
                layer_cnt <= layer_cnt + CNT_W'(1);
            // a new duplicate outranks a simultaneous clear
            if (dup)
                err_dup <= 1'b1;
            else if (err_clr)
                err_dup <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sdp_x_alu_cfg_triosy_sync_rx.sv
// Per-cycle vector table driven through a scoreboard queue against two
// instances (2-bit and 8-bit layer counters) sharing the same stimulus.
module tb_sdp_x_alu_cfg_triosy_sync_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] lz, en;
    logic       rdy, clr;

    logic       vld_a, err_a, vld_b, err_b;
    logic [3:0] pend_a, pend_b;
    logic [1:0] cnt_a;
    logic [7:0] cnt_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sdp_x_alu_cfg_triosy_sync_rx #(.NUM_CH(4), .CNT_W(2)) dut_a (
        .nvdla_core_clk(clk), .nvdla_core_rst(rst), .triosy_lz(lz), .ch_en(en),
        .done_vld(vld_a), .done_rdy(rdy), .pend_mask(pend_a), .layer_cnt(cnt_a),
        .err_dup(err_a), .err_clr(clr));

    sdp_x_alu_cfg_triosy_sync_rx #(.NUM_CH(4), .CNT_W(8)) dut_b (
        .nvdla_core_clk(clk), .nvdla_core_rst(rst), .triosy_lz(lz), .ch_en(en),
        .done_vld(vld_b), .done_rdy(rdy), .pend_mask(pend_b), .layer_cnt(cnt_b),
        .err_dup(err_b), .err_clr(clr));

    typedef struct {
        logic [3:0] lz, en;
        logic       rdy, clr;
        logic       vld;
        logic [3:0] pend;
        logic       err;
        logic [7:0] cnt;
    } vec_t;

    typedef struct {
        logic       vld;
        logic [3:0] pend;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic add(input logic [3:0] l, input logic [3:0] e, input logic r, input logic c,
                       input logic v, input logic [3:0] p, input logic er, input logic [7:0] n);
        vec_t t;
        t.lz = l; t.en = e; t.rdy = r; t.clr = c;
        t.vld = v; t.pend = p; t.err = er; t.cnt = n;
        tbl.push_back(t);
    endtask

    task automatic apply(input vec_t t, input int idx);
        exp_t e, g;
        @(negedge clk);
        lz = t.lz; en = t.en; rdy = t.rdy; clr = t.clr;
        e.vld = t.vld; e.pend = t.pend; e.err = t.err; e.cnt = t.cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_empty row %0d", idx);
        end else begin
            g = sb.pop_front();
            chk($sformatf("vld_a[%0d]", idx), 32'(vld_a), 32'(g.vld));
            chk($sformatf("pend_a[%0d]", idx), 32'(pend_a), 32'(g.pend));
            chk($sformatf("err_a[%0d]", idx), 32'(err_a), 32'(g.err));
            chk($sformatf("cnt_a[%0d]", idx), 32'(cnt_a), 32'(g.cnt[1:0]));
            chk($sformatf("vld_b[%0d]", idx), 32'(vld_b), 32'(g.vld));
            chk($sformatf("cnt_b[%0d]", idx), 32'(cnt_b), 32'(g.cnt));
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_vld_a"}, 32'(vld_a), 0);
        chk({tag, "_pend_a"}, 32'(pend_a), 0);
        chk({tag, "_err_a"}, 32'(err_a), 0);
        chk({tag, "_cnt_a"}, 32'(cnt_a), 0);
        chk({tag, "_pend_b"}, 32'(pend_b), 0);
        chk({tag, "_cnt_b"}, 32'(cnt_b), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; lz = '0; en = '0; rdy = 1'b0; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_zero("reset");
        @(negedge clk) rst = 1'b0;

        //   lz      en      rdy clr  vld pend    err cnt
        // sequential strobes, rdy high
        add(4'b0001, 4'b1111, 1, 0,  0, 4'b0001, 0, 0);
        add(4'b0010, 4'b1111, 1, 0,  0, 4'b0011, 0, 0);
        add(4'b0100, 4'b1111, 1, 0,  0, 4'b0111, 0, 0);
        add(4'b1000, 4'b1111, 1, 0,  1, 4'b1111, 0, 0);
        add(4'b0000, 4'b1111, 1, 0,  0, 4'b0000, 0, 1);
        add(4'b0000, 4'b1111, 1, 0,  0, 4'b0000, 0, 1);
        // all strobes at once, backpressure
        add(4'b1111, 4'b1111, 0, 0,  1, 4'b1111, 0, 1);
        add(4'b0000, 4'b1111, 0, 0,  1, 4'b1111, 0, 1);
        add(4'b0000, 4'b1111, 0, 0,  1, 4'b1111, 0, 1);
        add(4'b0000, 4'b1111, 1, 0,  0, 4'b0000, 0, 2);
        // duplicates, clear, set-beats-clear
        add(4'b0001, 4'b1111, 1, 0,  0, 4'b0001, 0, 2);
        add(4'b0010, 4'b1111, 1, 0,  0, 4'b0011, 0, 2);
        add(4'b0010, 4'b1111, 1, 0,  0, 4'b0011, 1, 2);
        add(4'b0000, 4'b1111, 1, 1,  0, 4'b0011, 0, 2);
        add(4'b0001, 4'b1111, 1, 1,  0, 4'b0011, 1, 2);
        add(4'b0000, 4'b1111, 1, 1,  0, 4'b0011, 0, 2);
        add(4'b1100, 4'b1111, 1, 0,  1, 4'b1111, 0, 2);
        add(4'b0000, 4'b1111, 1, 0,  0, 4'b0000, 0, 3);
        // early strobes held while REPORT is stalled
        add(4'b1111, 4'b1111, 0, 0,  1, 4'b1111, 0, 3);
        add(4'b0001, 4'b1111, 0, 0,  1, 4'b1111, 0, 3);
        add(4'b0100, 4'b1111, 0, 0,  1, 4'b1111, 0, 3);
        add(4'b0100, 4'b1111, 0, 0,  1, 4'b1111, 1, 3);
        add(4'b0000, 4'b1111, 1, 1,  0, 4'b0101, 0, 4);
        add(4'b0010, 4'b1111, 1, 0,  0, 4'b0111, 0, 4);
        add(4'b1000, 4'b1111, 1, 0,  1, 4'b1111, 0, 4);
        add(4'b0000, 4'b1111, 1, 0,  0, 4'b0000, 0, 5);
        // partial enable: disabled strobes ignored
        add(4'b0010, 4'b0101, 1, 0,  0, 4'b0000, 0, 5);
        add(4'b1000, 4'b0101, 1, 0,  0, 4'b0000, 0, 5);
        add(4'b0001, 4'b0101, 1, 0,  0, 4'b0001, 0, 5);
        add(4'b1010, 4'b0101, 1, 0,  0, 4'b0001, 0, 5);
        add(4'b0100, 4'b0101, 1, 0,  1, 4'b0101, 0, 5);
        add(4'b0000, 4'b0101, 1, 0,  0, 4'b0000, 0, 6);
        // enable drop mid-layer, then a stale disabled bit
        add(4'b0011, 4'b1111, 1, 0,  0, 4'b0011, 0, 6);
        add(4'b0000, 4'b0000, 1, 0,  0, 4'b0000, 0, 6);
        add(4'b1111, 4'b0000, 1, 0,  0, 4'b0000, 0, 6);
        add(4'b0001, 4'b1111, 1, 0,  0, 4'b0001, 0, 6);
        add(4'b1110, 4'b1110, 1, 0,  1, 4'b1111, 0, 6);
        add(4'b0000, 4'b1110, 1, 0,  0, 4'b0000, 0, 7);
        // back-to-back layers: next layer complete on the handshake cycle
        add(4'b1111, 4'b1111, 1, 0,  1, 4'b1111, 0, 7);
        add(4'b1111, 4'b1111, 1, 0,  0, 4'b1111, 0, 8);
        add(4'b0000, 4'b1111, 1, 0,  1, 4'b1111, 0, 8);
        add(4'b0000, 4'b1111, 1, 0,  0, 4'b0000, 0, 9);
        // partial layer with an error, then async reset
        add(4'b0110, 4'b1111, 0, 0,  0, 4'b0110, 0, 9);
        add(4'b0010, 4'b1111, 0, 0,  0, 4'b0110, 1, 9);

        foreach (tbl[i]) apply(tbl[i], i);

        // assert reset between edges: outputs must clear before any clock edge
        @(negedge clk);
        lz = '0;
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        chk("async_rst_vld_b", 32'(vld_b), 0);
        chk("async_rst_err_b", 32'(err_b), 0);
        @(negedge clk) rst = 1'b0;

        // nothing collected before reset survives it
        add(4'b0001, 4'b1111, 0, 0,  0, 4'b0001, 0, 0);
        apply(tbl[tbl.size()-1], tbl.size()-1);

        chk("sb_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sdp_x_alu_cfg_triosy_sync_rx.md
Name: sdp_x_alu_cfg_triosy_sync_rx

Overview:
- Receiving end of the SDP X-ALU configuration triosy channels. The ALU core pulses one triosy "lz" strobe per config field (algo, src, shift, op) when it has consumed that field for the current layer.
- This block collects the strobes per layer and raises a single layer-done request toward the SDP register/CSB side. It holds that request under a valid/ready handshake and buffers strobes that arrive early for the next layer.
- Duplicate strobes within one layer are flagged with a sticky error.

Parameters:
- NUM_CH, 4: number of triosy channels collected.
- CNT_W, 8: width of the completed-layer counter.

Ports:
- nvdla_core_clk  input  1  core clock; all state changes on the rising edge.
- nvdla_core_rst  input  1  asynchronous, active-high reset.
- triosy_lz  input  NUM_CH  per-channel one-cycle done strobe from the ALU core.
- ch_en  input  NUM_CH  channel participates in layer completion; sampled every cycle.
- done_vld  output  1  layer-done request, registered.
- done_rdy  input  1  register side accepts the layer-done request.
- pend_mask  output  NUM_CH  channels already received for the layer being collected.
- layer_cnt  output  CNT_W  count of accepted layer-done handshakes.
- err_dup  output  1  sticky duplicate-strobe error.
- err_clr  input  1  synchronous clear of err_dup.

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, pend_mask=0, nxt_mask=0, done_vld=0, layer_cnt=0, err_dup=0. Reset mid-layer discards all collected strobes.
- Strobes are filtered as lz_v = triosy_lz & ch_en. Strobes on disabled channels are ignored and never flag an error.
- States: IDLE, COLLECT, REPORT.
- IDLE:
  - If ch_en==0, stay in IDLE and ignore all strobes.
  - Otherwise, any lz_v bit moves to COLLECT with pend_mask=lz_v.
  - If lz_v already equals ch_en, go directly to REPORT instead.
- COLLECT:
  - pend_mask <= pend_mask | lz_v.
  - Any lz_v bit already set in pend_mask sets err_dup. The OR still applies.
  - When (pend_mask|lz_v) & ch_en == ch_en, go to REPORT next cycle with done_vld=1.
  - Bits of pend_mask for channels no longer enabled do not block completion.
  - If ch_en drops to 0 in COLLECT, return to IDLE and clear pend_mask.
- REPORT:
  - done_vld=1 and held stable until done_rdy=1. There is no timeout.
  - Strobes arriving in REPORT accumulate into nxt_mask (next layer). A duplicate into nxt_mask sets err_dup.
  - On the handshake cycle (done_vld & done_rdy):
    - layer_cnt increments, wrapping 2^CNT_W-1 -> 0.
    - done_vld clears the next cycle.
    - pend_mask <= nxt_mask | lz_v and nxt_mask <= 0.
    - Next state: IDLE if that mask is 0; REPORT if that mask already covers ch_en; otherwise COLLECT.
- Latency: the last required strobe at cycle N gives done_vld=1 at cycle N+1. With done_rdy tied high, the handshake completes at N+1 and done_vld=0 at N+2. Maximum throughput is one layer per 2 cycles.
- err_dup: a set at the same cycle as err_clr wins (the flag stays 1). Otherwise err_clr drops it to 0 the next cycle.
- pend_mask is a registered output. nxt_mask is internal.

Test Plan:
- NUM_CH=4, ch_en=4'b1111; strobes on ch0..ch3 at cycles 1,2,3,4; done_rdy=1 -> pend_mask 0001,0011,0111; done_vld=1 at cycle 5 only; layer_cnt=1; err_dup=0.
- triosy_lz=4'b1111 in one cycle from IDLE with done_rdy=0 for 3 cycles -> done_vld rises next cycle and holds 3 cycles; after done_rdy=1, layer_cnt=1 and state IDLE.
- In COLLECT with pend_mask=0011, strobe ch1 again -> err_dup=1 next cycle, pend_mask stays 0011; err_clr=1 -> err_dup=0.
- REPORT held (done_rdy=0) while strobes arrive on ch0, then ch2 -> no early completion; after the handshake, pend_mask=0101 and state COLLECT; ch1 and ch3 strobes then give a second done_vld and layer_cnt=2.
- ch_en=4'b0101, strobes on ch1 and ch3 only -> no state change, no error; strobes on ch0 and ch2 -> done_vld.
- CNT_W=2, four layers completed -> layer_cnt 1,2,3,0. Assert nvdla_core_rst with pend_mask=0110 -> all outputs 0 immediately, without waiting for a clock edge.
